sdram_cmd_gen: RTL and testbench

SDRAM_CMD_GEN -- requirements
Module: sdram_cmd_gen

---
 rtl/sdram_cmd_gen.sv | 252 +++++++++++++++++++++++++
 tb/tb_sdram_cmd_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_gen.sv
// rtl/sdram_cmd_gen.sv - SDRAM command sequencer; define SDRAM_CMD_REG_EN for one extra output register stage
module sdram_cmd_gen #(
  parameter int ASIZE = 23,
  parameter int TRCD  = 3,
  parameter int TRP   = 3,
  parameter int TRFC  = 7,
  parameter int TMRD  = 2,
  parameter int TAP   = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             NOP,
  input  logic             READA,
  input  logic             WRITEA,
  input  logic             REFRESH,
  input  logic             PRECHARGE,
  input  logic             LOAD_MODE,
  input  logic [ASIZE-1:0] SADDR,
  input  logic             REF_REQ,
  input  logic             INIT_REQ,
  output logic             CM_ACK,
  output logic             REF_ACK,
  output logic [11:0]      SA,
  output logic [1:0]       BA,
  output logic             CS_N,
  output logic             RAS_N,
  output logic             CAS_N,
  output logic             WE_N,
  output logic             CKE,
  output logic             OE
);

  localparam int COL_W = 9;
  localparam int ROW_W = 12;
  localparam int CW    = 8;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  typedef enum logic [3:0] {
    IDLE, ACT, RCD, RW, APW, PRE, RPW, REF, RFCW, MRS, MRDW
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pre_pend_q, pre_pend_d;
  logic             ref_pend_q, ref_pend_d;
  logic             mrs_pend_q, mrs_pend_d;
  logic             wr_q, wr_d;
  logic [1:0]       bank_q, bank_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [11:0]      sa_q, sa_d;
  logic [1:0]       ba_q, ba_d;
  logic             oe_q, oe_d;
  logic             cm_ack_q, cm_ack_d;
  logic             ref_ack_q, ref_ack_d;
  logic             cke_q, cke_d;
  logic             sel_en;
  logic             issue_rw;
  logic             user_ok;

  // Decode the next state and the pin values to present on the next edge; each command
  // state loads its timing parameter minus one so the command cycle itself counts toward
  // the interval, and the final wait cycle falls straight into command selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
    pre_pend_d = pre_pend_q | PRECHARGE;
    ref_pend_d = ref_pend_q | REFRESH;
    mrs_pend_d = mrs_pend_q | LOAD_MODE;
    wr_d       = wr_q;
    bank_d     = bank_q;
    col_d      = col_q;
    cmd_d      = CMD_NOP;
    sa_d       = '0;
    ba_d       = '0;
    oe_d       = 1'b0;
    cm_ack_d   = 1'b0;
    ref_ack_d  = 1'b0;
    cke_d      = 1'b1;
    sel_en     = 1'b0;
    issue_rw   = 1'b0;
    user_ok    = ~INIT_REQ;

    unique case (state_q)
      IDLE: sel_en = 1'b1;
      ACT: begin
        if (cnt_q == '0) issue_rw = 1'b1;
        else             state_d  = RCD;
      end
      RCD: begin
        if (cnt_q == '0) issue_rw = 1'b1;
      end
      RW: begin
        if (cnt_q == '0) sel_en  = 1'b1;
        else             state_d = APW;
      end
      PRE: begin
        if (cnt_q == '0) sel_en  = 1'b1;
        else             state_d = RPW;
      end
      REF: begin
        if (cnt_q == '0) sel_en  = 1'b1;
        else             state_d = RFCW;
      end
      MRS: begin
        if (cnt_q == '0) sel_en  = 1'b1;
        else             state_d = MRDW;
      end
      APW, RPW, RFCW, MRDW: begin
        if (cnt_q == '0) sel_en = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (issue_rw) begin
      state_d  = RW;
      cnt_d    = CW'(TAP - 1);
      cmd_d    = wr_q ? CMD_WRITE : CMD_READ;
      sa_d     = {1'b0, 1'b1, 1'b0, col_q};
      ba_d     = bank_q;
      oe_d     = wr_q;
      cm_ack_d = 1'b1;
    end

    if (sel_en) begin
      state_d = IDLE;
      if (pre_pend_q) begin
        state_d    = PRE;
        cnt_d      = CW'(TRP - 1);
        cmd_d      = CMD_PRE;
        sa_d       = 12'h400;
        pre_pend_d = 1'b0;
      end else if (ref_pend_q) begin
        state_d    = REF;
        cnt_d      = CW'(TRFC - 1);
        cmd_d      = CMD_REF;
        ref_pend_d = 1'b0;
      end else if (mrs_pend_q) begin
        state_d    = MRS;
        cnt_d      = CW'(TMRD - 1);
        cmd_d      = CMD_MRS;
        sa_d       = SADDR[11:0];
        mrs_pend_d = 1'b0;
      end else if (user_ok && REF_REQ) begin
        state_d   = REF;
        cnt_d     = CW'(TRFC - 1);
        cmd_d     = CMD_REF;
        ref_ack_d = 1'b1;
      end else if (user_ok && !NOP && (READA || WRITEA)) begin
        state_d = ACT;
        cnt_d   = CW'(TRCD - 1);
        cmd_d   = CMD_ACT;
        sa_d    = SADDR[COL_W +: ROW_W];
        ba_d    = SADDR[ASIZE-1 -: 2];
        wr_d    = ~READA;
        bank_d  = SADDR[ASIZE-1 -: 2];
        col_d   = SADDR[COL_W-1:0];
      end
    end
  end

  // Sequencer state, pending init flags and registered pin drivers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pre_pend_q <= 1'b0;
      ref_pend_q <= 1'b0;
      mrs_pend_q <= 1'b0;
      wr_q       <= 1'b0;
      bank_q     <= '0;
      col_q      <= '0;
      cmd_q      <= CMD_DESEL;
      sa_q       <= '0;
      ba_q       <= '0;
      oe_q       <= 1'b0;
      cm_ack_q   <= 1'b0;
      ref_ack_q  <= 1'b0;
      cke_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_pend_q <= pre_pend_d;
      ref_pend_q <= ref_pend_d;
      mrs_pend_q <= mrs_pend_d;
      wr_q       <= wr_d;
      bank_q     <= bank_d;
      col_q      <= col_d;
      cmd_q      <= cmd_d;
      sa_q       <= sa_d;
      ba_q       <= ba_d;
      oe_q       <= oe_d;
      cm_ack_q   <= cm_ack_d;
      ref_ack_q  <= ref_ack_d;
      cke_q      <= cke_d;
    end
  end

`ifdef SDRAM_CMD_REG_EN
  logic [3:0]  cmd_p_q;
  logic [11:0] sa_p_q;
  logic [1:0]  ba_p_q;
  logic        oe_p_q;
  logic        cm_ack_p_q;
  logic        ref_ack_p_q;

  // Retime pins and acknowledges together so each ack stays on its command cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_p_q     <= CMD_DESEL;
      sa_p_q      <= '0;
      ba_p_q      <= '0;
      oe_p_q      <= 1'b0;
      cm_ack_p_q  <= 1'b0;
      ref_ack_p_q <= 1'b0;
    end else begin
      cmd_p_q     <= cmd_q;
      sa_p_q      <= sa_q;
      ba_p_q      <= ba_q;
      oe_p_q      <= oe_q;
      cm_ack_p_q  <= cm_ack_q;
      ref_ack_p_q <= ref_ack_q;
    end
  end

  assign {CS_N, RAS_N, CAS_N, WE_N} = cmd_p_q;
  assign SA      = sa_p_q;
  assign BA      = ba_p_q;
  assign OE      = oe_p_q;
  assign CM_ACK  = cm_ack_p_q;
  assign REF_ACK = ref_ack_p_q;
`else
  assign {CS_N, RAS_N, CAS_N, WE_N} = cmd_q;
  assign SA      = sa_q;
  assign BA      = ba_q;
  assign OE      = oe_q;
  assign CM_ACK  = cm_ack_q;
  assign REF_ACK = ref_ack_q;
`endif

  assign CKE = cke_q;

endmodule

// File: tb/tb_sdram_cmd_gen.sv
// tb/tb_sdram_cmd_gen.sv - scoreboard bench for sdram_cmd_gen
module tb_sdram_cmd_gen;

`ifdef SDRAM_CMD_REG_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif

  localparam logic [3:0] P_ACT   = 4'b0011;
  localparam logic [3:0] P_READ  = 4'b0101;
  localparam logic [3:0] P_WRITE = 4'b0100;
  localparam logic [3:0] P_PRE   = 4'b0010;
  localparam logic [3:0] P_REF   = 4'b0001;
  localparam logic [3:0] P_MRS   = 4'b0000;

  logic        CLK;
  logic        RESET;
  logic        NOP, READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE;
  logic [22:0] SADDR;
  logic        REF_REQ, INIT_REQ;
  logic        CM_ACK, REF_ACK;
  logic [11:0] SA;
  logic [1:0]  BA;
  logic        CS_N, RAS_N, CAS_N, WE_N, CKE, OE;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    logic [11:0] sa;
    logic [1:0] ba;
    logic       oe;
    logic       cm_ack;
    logic       ref_ack;
  } exp_t;

  exp_t exp_q[$];

  sdram_cmd_gen dut (
    .CLK(CLK), .RESET(RESET), .NOP(NOP), .READA(READA), .WRITEA(WRITEA),
    .REFRESH(REFRESH), .PRECHARGE(PRECHARGE), .LOAD_MODE(LOAD_MODE),
    .SADDR(SADDR), .REF_REQ(REF_REQ), .INIT_REQ(INIT_REQ),
    .CM_ACK(CM_ACK), .REF_ACK(REF_ACK), .SA(SA), .BA(BA),
    .CS_N(CS_N), .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N),
    .CKE(CKE), .OE(OE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1);
  end

  // Monitor: every command cycle pops one expectation; other cycles must carry no flags
  always @(negedge CLK) begin
    logic [3:0] pins;
    exp_t e;
    pins = {CS_N, RAS_N, CAS_N, WE_N};
    if (!CS_N && pins != 4'b0111) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd got pins=%b sa=%h ba=%0d cyc=%0d, required no command", pins, SA, BA, cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL cmd_cycle pins=%b got cyc=%0d required %0d", pins, cyc, e.cyc);
        end
        checks++;
        if ({pins, SA, BA, OE, CM_ACK, REF_ACK} !== {e.cmd, e.sa, e.ba, e.oe, e.cm_ack, e.ref_ack}) begin
          errors++;
          $display("FAIL cmd_fields got pins=%b sa=%h ba=%0d oe=%b ack=%b rack=%b required pins=%b sa=%h ba=%0d oe=%b ack=%b rack=%b",
                   pins, SA, BA, OE, CM_ACK, REF_ACK, e.cmd, e.sa, e.ba, e.oe, e.cm_ack, e.ref_ack);
        end
      end
    end else if (cyc > 0) begin
      checks++;
      if ({OE, CM_ACK, REF_ACK} !== 3'b000) begin
        errors++;
        $display("FAIL idle_flags cyc=%0d got oe/ack/rack=%b required 000", cyc, {OE, CM_ACK, REF_ACK});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input int c, input logic [3:0] cmd, input logic [11:0] sa,
                      input logic [1:0] ba, input logic oe, input logic ack, input logic rack);
    exp_t e;
    e.cyc = c; e.cmd = cmd; e.sa = sa; e.ba = ba; e.oe = oe; e.cm_ack = ack; e.ref_ack = rack;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_pins(input string name);
    checks++;
    if ({CS_N, RAS_N, CAS_N, WE_N, CKE, SA, BA, OE, CM_ACK, REF_ACK} !== {4'b1111, 1'b0, 12'h000, 2'b00, 3'b000}) begin
      errors++;
      $display("FAIL %s got pins=%b cke=%b sa=%h ba=%0d oe=%b ack=%b rack=%b required pins=1111 cke=0 sa=000 ba=0 flags=000",
               name, {CS_N, RAS_N, CAS_N, WE_N}, CKE, SA, BA, OE, CM_ACK, REF_ACK);
    end
  endtask

  task automatic check_cke(input string name, input logic req);
    checks++;
    if (CKE !== req) begin
      errors++;
      $display("FAIL %s got cke=%b required %b", name, CKE, req);
    end
  endtask

  initial begin
    int k;
    RESET = 1'b1; NOP = 1'b0; READA = 1'b0; WRITEA = 1'b0;
    REFRESH = 1'b0; PRECHARGE = 1'b0; LOAD_MODE = 1'b0;
    SADDR = '0; REF_REQ = 1'b0; INIT_REQ = 1'b0;

    // Reset state and CKE release
    tick(3);
    check_reset_pins("reset_state");
    RESET = 1'b0;
    tick(1);
    check_cke("cke_after_reset", 1'b1);
    tick(4);

    // READ: ACTIVE row/bank, READ with A10 three cycles later
    k = cyc;
    SADDR = {2'd2, 12'h2A1, 9'h0F3};
    READA = 1'b1;
    push(k + 1 + L, P_ACT,  12'h2A1, 2'd2, 1'b0, 1'b0, 1'b0);
    push(k + 4 + L, P_READ, 12'h4F3, 2'd2, 1'b0, 1'b1, 1'b0);
    tick(1);
    READA = 1'b0;
    tick(11);

    // WRITE: OE only on the WRITE cycle
    k = cyc;
    SADDR = {2'd1, 12'h0FF, 9'h1AB};
    WRITEA = 1'b1;
    push(k + 1 + L, P_ACT,   12'h0FF, 2'd1, 1'b0, 1'b0, 1'b0);
    push(k + 4 + L, P_WRITE, 12'h5AB, 2'd1, 1'b1, 1'b1, 1'b0);
    tick(1);
    WRITEA = 1'b0;
    tick(11);

    // WRITEA held across the auto-precharge wait starts a second sequence
    k = cyc;
    SADDR = {2'd3, 12'hFFF, 9'h000};
    WRITEA = 1'b1;
    push(k + 1 + L,  P_ACT,   12'hFFF, 2'd3, 1'b0, 1'b0, 1'b0);
    push(k + 4 + L,  P_WRITE, 12'h400, 2'd3, 1'b1, 1'b1, 1'b0);
    push(k + 8 + L,  P_ACT,   12'hFFF, 2'd3, 1'b0, 1'b0, 1'b0);
    push(k + 11 + L, P_WRITE, 12'h400, 2'd3, 1'b1, 1'b1, 1'b0);
    tick(8);
    WRITEA = 1'b0;
    tick(10);

    // REF_REQ beats READA; ACTIVE follows seven cycles after the refresh
    k = cyc;
    SADDR = {2'd0, 12'h123, 9'h1FF};
    REF_REQ = 1'b1;
    READA = 1'b1;
    push(k + 1 + L,  P_REF,  12'h000, 2'd0, 1'b0, 1'b0, 1'b1);
    push(k + 8 + L,  P_ACT,  12'h123, 2'd0, 1'b0, 1'b0, 1'b0);
    push(k + 11 + L, P_READ, 12'h5FF, 2'd0, 1'b0, 1'b1, 1'b0);
    tick(1);
    REF_REQ = 1'b0;
    tick(7);
    READA = 1'b0;
    tick(10);

    // Init: pending REFRESH, then PRECHARGE (double pulse absorbed) and LOAD MODE;
    // READA is ignored while INIT_REQ is high
    k = cyc;
    SADDR = 23'h1A5233;
    INIT_REQ = 1'b1;
    READA = 1'b1;
    REFRESH = 1'b1;
    push(k + 2 + L,  P_REF, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0);
    push(k + 9 + L,  P_PRE, 12'h400, 2'd0, 1'b0, 1'b0, 1'b0);
    push(k + 12 + L, P_MRS, 12'h233, 2'd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    REFRESH = 1'b0;
    tick(3);
    PRECHARGE = 1'b1;
    LOAD_MODE = 1'b1;
    tick(1);
    PRECHARGE = 1'b0;
    LOAD_MODE = 1'b0;
    tick(1);
    PRECHARGE = 1'b1;
    tick(1);
    PRECHARGE = 1'b0;
    tick(9);
    READA = 1'b0;
    tick(1);
    INIT_REQ = 1'b0;
    tick(6);

    // Reset while waiting in RCD: READ never issues, CKE drops then returns
    k = cyc;
    SADDR = {2'd1, 12'h055, 9'h0AA};
    READA = 1'b1;
    push(k + 1 + L, P_ACT, 12'h055, 2'd1, 1'b0, 1'b0, 1'b0);
    tick(1);
    READA = 1'b0;
    tick(1);
    RESET = 1'b1;
    tick(1);
    check_reset_pins("reset_mid_rcd");
    tick(1);
    RESET = 1'b0;
    tick(1);
    check_cke("cke_after_mid_reset", 1'b1);
    tick(12);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_cmds got %0d unseen required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
